// File: rtl/regfile_mmio.sv
// -----------------------------------------------------------------------------
// regfile_mmio
//   Processor register file with two combinational read ports, one write port,
//   r0 hard-wired to zero and an optional write-to-read bypass. Two address
//   windows are memory-mapped to peripherals:
//     * output channels (IO_BASE..IO_BASE+IO_COUNT-1): the stored registers
//       drive io_out directly, and each write raises a one-cycle io_update pulse;
//     * input channels (IN_BASE..IN_BASE+IN_COUNT-1): words are captured through
//       a valid/ready handshake into a single-entry slot per channel. The
//       processor consumes a word by writing the channel register.
//   STATUS_ADDR is read-only and returns the per-channel full flags.
//
// Ports
//   clock            rising-edge clock
//   ctrl_reset       asynchronous active-high reset
//   ctrl_writeEnable processor write enable
//   ctrl_writeReg    write address
//   data_writeReg    write data
//   ctrl_readRegA/B  read addresses
//   data_readRegA/B  read data (combinational)
//   io_out           output channel k at bits [k*DATA_W +: DATA_W]
//   io_update        one-cycle pulse per output channel after it is written
//   in_data          input channel j capture word at bits [j*DATA_W +: DATA_W]
//   in_valid         input channel word valid
//   in_ready         input channel slot empty
// -----------------------------------------------------------------------------
module regfile_mmio #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 5,
    parameter int BYPASS      = 1,
    parameter int IO_BASE     = 18,
    parameter int IO_COUNT    = 5,
    parameter int IN_BASE     = 23,
    parameter int IN_COUNT    = 3,
    parameter int STATUS_ADDR = 31
) (
    input  logic                         clock,
    input  logic                         ctrl_reset,
    input  logic                         ctrl_writeEnable,
    input  logic [ADDR_W-1:0]            ctrl_writeReg,
    input  logic [DATA_W-1:0]            data_writeReg,
    input  logic [ADDR_W-1:0]            ctrl_readRegA,
    input  logic [ADDR_W-1:0]            ctrl_readRegB,
    output logic [DATA_W-1:0]            data_readRegA,
    output logic [DATA_W-1:0]            data_readRegB,
    output logic [IO_COUNT*DATA_W-1:0]   io_out,
    output logic [IO_COUNT-1:0]          io_update,
    input  logic [IN_COUNT*DATA_W-1:0]   in_data,
    input  logic [IN_COUNT-1:0]          in_valid,
    output logic [IN_COUNT-1:0]          in_ready
);

    localparam int NREGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] STATUS_A = ADDR_W'(STATUS_ADDR);
    localparam logic [ADDR_W-1:0] ZERO_A   = '0;

    // Window legality: both windows inside the address space, disjoint,
    // and clear of r0 and the status register.
    localparam bit PARAMS_OK =
        (IO_COUNT >= 1) && (IN_COUNT >= 1) && (IN_COUNT <= DATA_W) &&
        (IO_BASE > 0) && (IO_BASE + IO_COUNT <= NREGS) &&
        (IN_BASE > 0) && (IN_BASE + IN_COUNT <= NREGS) &&
        (STATUS_ADDR > 0) && (STATUS_ADDR < NREGS) &&
        ((IO_BASE + IO_COUNT <= IN_BASE) || (IN_BASE + IN_COUNT <= IO_BASE)) &&
        !((STATUS_ADDR >= IO_BASE) && (STATUS_ADDR < IO_BASE + IO_COUNT)) &&
        !((STATUS_ADDR >= IN_BASE) && (STATUS_ADDR < IN_BASE + IN_COUNT));

    generate
        if (!PARAMS_OK) begin : g_bad_params
            $error("regfile_mmio: illegal IO/IN window or STATUS_ADDR placement");
        end
    endgenerate

    logic [DATA_W-1:0]   regs_q [NREGS];
    logic [DATA_W-1:0]   regs_d [NREGS];
    logic [IN_COUNT-1:0] full_q, full_d;
    logic [IO_COUNT-1:0] io_update_q, io_update_d;

    logic              wr_ok;
    logic [DATA_W-1:0] status_word;
    logic [DATA_W-1:0] stored_a, stored_b;

    // Writes to r0 and the status register are silently discarded.
    assign wr_ok = ctrl_writeEnable && (ctrl_writeReg != ZERO_A) && (ctrl_writeReg != STATUS_A);

    assign status_word = DATA_W'(full_q);

    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        full_d      = full_q;
        io_update_d = '0;

        if (wr_ok) begin
            regs_d[ctrl_writeReg] = data_writeReg;
        end

        for (int k = 0; k < IO_COUNT; k++) begin
            if (wr_ok && (ctrl_writeReg == ADDR_W'(IO_BASE + k))) begin
                io_update_d[k] = 1'b1;
            end
        end

        for (int j = 0; j < IN_COUNT; j++) begin
            // A processor write to the channel register consumes the word.
            if (wr_ok && (ctrl_writeReg == ADDR_W'(IN_BASE + j))) begin
                full_d[j] = 1'b0;
            end
            // Capture is evaluated last so it overrides a same-edge processor
            // write to the same (necessarily empty) channel.
            if (in_valid[j] && !full_q[j]) begin
                regs_d[IN_BASE + j] = in_data[j*DATA_W +: DATA_W];
                full_d[j]           = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            full_q      <= '0;
            io_update_q <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            full_q      <= full_d;
            io_update_q <= io_update_d;
        end
    end

    // Read selection: r0 and status are decoded ahead of the bypass so they
    // can never be forwarded; input captures only appear via stored values.
    function automatic logic [DATA_W-1:0] read_sel(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] stored,
        input logic [DATA_W-1:0] status,
        input logic              wr_hit_ok,
        input logic [ADDR_W-1:0] wr_addr,
        input logic [DATA_W-1:0] wr_data
    );
        if (addr == ZERO_A) begin
            return '0;
        end else if (addr == STATUS_A) begin
            return status;
        end else if ((BYPASS != 0) && wr_hit_ok && (addr == wr_addr)) begin
            return wr_data;
        end else begin
            return stored;
        end
    endfunction

    assign stored_a = regs_q[ctrl_readRegA];
    assign stored_b = regs_q[ctrl_readRegB];

    assign data_readRegA = read_sel(ctrl_readRegA, stored_a, status_word,
                                    wr_ok, ctrl_writeReg, data_writeReg);
    assign data_readRegB = read_sel(ctrl_readRegB, stored_b, status_word,
                                    wr_ok, ctrl_writeReg, data_writeReg);

    generate
        for (genvar k = 0; k < IO_COUNT; k++) begin : g_io
            assign io_out[k*DATA_W +: DATA_W] = regs_q[IO_BASE + k];
        end
    endgenerate

    assign io_update = io_update_q;
    assign in_ready  = ~full_q;

endmodule
